// File: rtl/conv_sched_if.sv
// Interface for the convolution sequencer.
// Carries the frame control, image read, MAC tap and write-back signals.
interface conv_sched_if #(
    parameter int unsigned AW = 12
) ();
    logic          start;
    logic          busy;
    logic          done;
    logic          ird;
    logic [AW-1:0] iaddr;
    logic          tap_vld;
    logic [3:0]    tap_idx;
    logic          tap_pad;
    logic          tap_first;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack;

    // Sequencer side
    modport master (
        input  start, wr_ack,
        output busy, done, ird, iaddr, tap_vld, tap_idx, tap_pad, tap_first, wr_req, wr_addr
    );

    // Memory / MAC / controller side
    modport slave (
        output start, wr_ack,
        input  busy, done, ird, iaddr, tap_vld, tap_idx, tap_pad, tap_first, wr_req, wr_addr
    );
endinterface

// File: rtl/conv_sched.sv
// 3x3 convolution sequencer: raster-scans output pixels, issues the nine
// window reads (padding taps outside the image), tags taps for the MAC and
// requests a write-back of each result through a req/ack handshake.
module conv_sched #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 64,
    parameter int unsigned AW      = 12,
    parameter int unsigned MAC_LAT = 1
) (
    input logic         clk,
    input logic         reset,
    conv_sched_if.master bus
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    cnt_q, cnt_d;

    logic          busy_q, done_q, ird_q;
    logic [AW-1:0] iaddr_q;
    logic          tap_vld_q, tap_pad_q, tap_first_q;
    logic [3:0]    tap_idx_q;
    logic          wr_req_q;
    logic [AW-1:0] wr_addr_q;

    logic          issue_d;
    logic          fetch_q;

    // True when tap k of the window centred on (x, y) lies inside the image.
    // Bounds are explicit compares so coordinates never wrap.
    function automatic logic tap_in(input logic [3:0] k, input logic [XW-1:0] x,
                                    input logic [YW-1:0] y);
        logic [3:0] r;
        logic [3:0] c;
        r = k / 4'd3;
        c = k - r * 4'd3;
        return !((c == 4'd0 && x == '0) ||
                 (c == 4'd2 && x == XW'(IMG_W - 1)) ||
                 (r == 4'd0 && y == '0) ||
                 (r == 4'd2 && y == YW'(IMG_H - 1)));
    endfunction

    // Address of tap k; only meaningful when tap_in() holds.
    function automatic logic [AW-1:0] tap_addr(input logic [3:0] k, input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        logic [3:0]    r;
        logic [3:0]    c;
        logic [XW-1:0] px;
        logic [YW-1:0] py;
        r  = k / 4'd3;
        c  = k - r * 4'd3;
        px = x + XW'(c) - XW'(1);
        py = y + YW'(r) - YW'(1);
        return (AW'(py) << XW) + AW'(px);
    endfunction

    // Next-state logic: frame scan, tap counter, drain counter and handshake.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                    k_d     = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StFetch: begin
                if (k_q == 4'd8) begin
                    state_d = StDrain;
                    k_d     = '0;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StDrain: begin
                // Covers the last tap landing plus the MAC pipeline.
                if (cnt_q == 3'(MAC_LAT)) begin
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWrite: begin
                if (bus.wr_ack) begin
                    if (x_q == XW'(IMG_W - 1) && y_q == YW'(IMG_H - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                        k_d     = '0;
                        if (x_q == XW'(IMG_W - 1)) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                x_d     = '0;
                y_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign issue_d = (state_d == StFetch) && tap_in(k_d, x_d, y_d);
    assign fetch_q = (state_q == StFetch);

    // State and registered outputs; the tap tags trail the issue cycle by one
    // so they line up with the returning image data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ird_q       <= 1'b0;
            iaddr_q     <= '0;
            tap_vld_q   <= 1'b0;
            tap_idx_q   <= '0;
            tap_pad_q   <= 1'b0;
            tap_first_q <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d == StFetch) || (state_d == StDrain) || (state_d == StWrite);
            done_q      <= (state_d == StDone);
            ird_q       <= issue_d;
            if (issue_d) begin
                iaddr_q <= tap_addr(k_d, x_d, y_d);
            end
            tap_vld_q   <= fetch_q;
            tap_idx_q   <= fetch_q ? k_q : 4'd0;
            tap_pad_q   <= fetch_q && !tap_in(k_q, x_q, y_q);
            tap_first_q <= fetch_q && (k_q == 4'd0);
            wr_req_q    <= (state_d == StWrite);
            if (state_d == StWrite) begin
                wr_addr_q <= (AW'(y_d) << XW) + AW'(x_d);
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ird       = ird_q;
    assign bus.iaddr     = iaddr_q;
    assign bus.tap_vld   = tap_vld_q;
    assign bus.tap_idx   = tap_idx_q;
    assign bus.tap_pad   = tap_pad_q;
    assign bus.tap_first = tap_first_q;
    assign bus.wr_req    = wr_req_q;
    assign bus.wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: records one full 64x64 frame cycle by cycle
// and checks selected pixels against hand-computed tap tables, plus reset,
// backpressure, frame totals and done timing.
module tb_conv_sched;

    localparam int unsigned AW   = 12;
    localparam int          MAXC = 49400;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    conv_sched_if #(.AW(AW)) bus ();

    conv_sched #(
        .IMG_W  (64),
        .IMG_H  (64),
        .AW     (AW),
        .MAC_LAT(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle trace of frame 1; cycle 1 is the first cycle after start is accepted.
    logic          rec_ird     [MAXC];
    logic [AW-1:0] rec_iaddr   [MAXC];
    logic          rec_vld     [MAXC];
    logic [3:0]    rec_idx     [MAXC];
    logic          rec_pad     [MAXC];
    logic          rec_first   [MAXC];
    logic          rec_wrreq   [MAXC];
    logic [AW-1:0] rec_wraddr  [MAXC];
    logic          rec_busy    [MAXC];

    // Hand tables per pixel: ird, iaddr (held value on padded taps), tap_pad.
    int ird_0_0   [9] = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
    int adr_0_0   [9] = '{0, 0, 0, 0, 0, 1, 1, 64, 65};
    int pad_0_0   [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    int ird_5_2   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int adr_5_2   [9] = '{68, 69, 70, 132, 133, 134, 196, 197, 198};
    int pad_5_2   [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int ird_10_0  [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    int adr_10_0  [9] = '{74, 74, 74, 9, 10, 11, 73, 74, 75};
    int pad_10_0  [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    int adr_11_0  [9] = '{75, 75, 75, 10, 11, 12, 74, 75, 76};
    int ird_63_0  [9] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
    int adr_63_0  [9] = '{127, 127, 127, 62, 63, 63, 126, 127, 127};
    int pad_63_0  [9] = '{1, 1, 1, 0, 0, 1, 0, 0, 1};
    int ird_0_1   [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
    int adr_0_1   [9] = '{127, 0, 1, 1, 64, 65, 65, 128, 129};
    int pad_0_1   [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    int ird_63_63 [9] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    int adr_63_63 [9] = '{4030, 4031, 4031, 4094, 4095, 4095, 4095, 4095, 4095};
    int pad_63_63 [9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {29'd0, bus.busy, bus.done, bus.ird, bus.iaddr, bus.tap_vld, bus.tap_idx,
                bus.tap_pad, bus.tap_first, bus.wr_req, bus.wr_addr};
    endfunction

    // Pixel p = y*64+x starts issuing at cycle 1+12p; the 5-cycle stall at
    // pixel 10 delays every later pixel by 5.
    task automatic check_pixel(input string name, input int p, input int e_ird [9],
                               input int e_adr [9], input int e_pad [9]);
        int base;
        base = 1 + 12 * p + ((p > 10) ? 5 : 0);
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("%s ird k%0d", name, k), rec_ird[base+k], e_ird[k]);
            check_eq($sformatf("%s iaddr k%0d", name, k), rec_iaddr[base+k], e_adr[k]);
            check_eq($sformatf("%s tap_vld k%0d", name, k), rec_vld[base+k+1], 1);
            check_eq($sformatf("%s tap_idx k%0d", name, k), rec_idx[base+k+1], k);
            check_eq($sformatf("%s tap_pad k%0d", name, k), rec_pad[base+k+1], e_pad[k]);
            check_eq($sformatf("%s tap_first k%0d", name, k), rec_first[base+k+1], k == 0);
        end
        check_eq($sformatf("%s wr_req early", name), rec_wrreq[base+10], 0);
        check_eq($sformatf("%s wr_req", name), rec_wrreq[base+11], 1);
        check_eq($sformatf("%s wr_addr", name), rec_wraddr[base+11], p);
    endtask

    int done_cyc;
    int dc;
    int held;
    int n_wrreq, n_acc, order_err, n_ird, n_vld, n_first, n_done, ird_in_write;
    int quiet_bad;

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.wr_ack  = 1'b0;
        #1;
        check_eq("reset outputs", outs_vec(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle with start low; wr_ack high must be ignored.
        bus.wr_ack = 1'b1;
        quiet_bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outs_vec() != 0) quiet_bad++;
        end
        check_eq("idle quiet", quiet_bad, 0);

        // Mid-clock reset pulse while idle.
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_eq("reset mid-clock idle", outs_vec(), 0);
        @(negedge clk);
        reset = 1'b1;

        // Frame 1.
        @(negedge clk);
        bus.start = 1'b1;
        held = 0; done_cyc = -1;
        n_wrreq = 0; n_acc = 0; order_err = 0; n_ird = 0; n_vld = 0; n_first = 0;
        n_done = 0; ird_in_write = 0;
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk);
            rec_ird[c]    = bus.ird;
            rec_iaddr[c]  = bus.iaddr;
            rec_vld[c]    = bus.tap_vld;
            rec_idx[c]    = bus.tap_idx;
            rec_pad[c]    = bus.tap_pad;
            rec_first[c]  = bus.tap_first;
            rec_wrreq[c]  = bus.wr_req;
            rec_wraddr[c] = bus.wr_addr;
            rec_busy[c]   = bus.busy;
            // Backpressure: withhold ack for the first 5 request cycles at pixel (10,0).
            if (bus.wr_req && bus.wr_addr == 12'd10 && held < 5) begin
                bus.wr_ack = 1'b0;
                held++;
            end else begin
                bus.wr_ack = 1'b1;
            end
            if (bus.wr_req) n_wrreq++;
            if (bus.wr_req && bus.wr_ack) begin
                if (bus.wr_addr != AW'(n_acc)) order_err++;
                n_acc++;
            end
            if (bus.wr_req && bus.ird) ird_in_write++;
            if (bus.ird) n_ird++;
            if (bus.tap_vld) n_vld++;
            if (bus.tap_first) n_first++;
            if (bus.done) n_done++;
            if (c == 1) bus.start = 1'b0;
            if (c == 50) bus.start = 1'b1;
            if (c == 51) bus.start = 1'b0;
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end

        check_eq("done cycle", done_cyc, 12 * 4096 + 1 + 5);
        dc = (done_cyc > 1) ? done_cyc : 2;
        check_eq("busy at done", rec_busy[dc], 0);
        check_eq("busy before done", rec_busy[dc-1], 1);
        check_eq("busy after start", rec_busy[1], 1);
        check_eq("tap_vld before first tap", rec_vld[1], 0);

        check_pixel("px(0,0)", 0, ird_0_0, adr_0_0, pad_0_0);
        check_pixel("px(10,0)", 10, ird_10_0, adr_10_0, pad_10_0);
        for (int c = 132; c <= 137; c++) begin
            check_eq($sformatf("stall wr_req c%0d", c), rec_wrreq[c], 1);
            check_eq($sformatf("stall wr_addr c%0d", c), rec_wraddr[c], 10);
            check_eq($sformatf("stall ird c%0d", c), rec_ird[c], 0);
        end
        check_eq("wr_req drop after ack", rec_wrreq[138], 0);
        check_pixel("px(11,0)", 11, ird_10_0, adr_11_0, pad_10_0);
        check_pixel("px(5,2)", 133, ird_5_2, adr_5_2, pad_5_2);
        check_pixel("px(63,0)", 63, ird_63_0, adr_63_0, pad_63_0);
        check_pixel("px(0,1)", 64, ird_0_1, adr_0_1, pad_0_1);
        check_pixel("px(63,63)", 4095, ird_63_63, adr_63_63, pad_63_63);

        check_eq("wr_req cycles", n_wrreq, 4096 + 5);
        check_eq("writes accepted", n_acc, 4096);
        check_eq("wr_addr order errors", order_err, 0);
        check_eq("ird during write", ird_in_write, 0);
        check_eq("ird count", n_ird, 9 * 4096 - 764);
        check_eq("tap_vld count", n_vld, 9 * 4096);
        check_eq("tap_first count", n_first, 4096);
        check_eq("done pulses", n_done, 1);

        // Back in IDLE one cycle after done; a fresh start runs a new frame.
        @(negedge clk);
        check_eq("done one cycle", bus.done, 0);
        check_eq("busy idle after done", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("frame2 busy", bus.busy, 1);
        check_eq("frame2 tap0 ird", bus.ird, 0);
        @(negedge clk);
        check_eq("frame2 tap_vld", bus.tap_vld, 1);
        check_eq("frame2 tap_first", bus.tap_first, 1);
        check_eq("frame2 tap_pad", bus.tap_pad, 1);

        // Abort mid-frame with a mid-clock reset.
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_eq("reset mid-frame", outs_vec(), 0);
        @(negedge clk);
        reset = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.ird || bus.wr_req || bus.tap_vld) quiet_bad++;
        end
        check_eq("quiet after abort", quiet_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer that drives the 3x3 convolution MAC datapath over a 64x64 image.
- Scans output pixels in raster order and issues the nine window reads to image memory.
- Flags zero-padded taps and tags each returned datum with its kernel tap index.
- After each window, requests a write-back of the result into layer-0 memory through an ack handshake.

Parameters:
- IMG_W, 64, image width in pixels (power of two).
- IMG_H, 64, image height in pixels.
- AW, 12, address width; equals log2(IMG_W*IMG_H).
- MAC_LAT, 1, cycles from the last tap to a valid MAC result (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin one frame; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last write-back is acked.
- ird  output  1  image read strobe; data returns on idata one cycle later (external).
- iaddr  output  AW  image read address, y*IMG_W+x.
- tap_vld  output  1  MAC input valid, aligned with idata.
- tap_idx  output  4  kernel tap 0..8 (row-major, 0 = top-left), aligned with tap_vld.
- tap_pad  output  1  tap lies outside the image; MAC uses 0, not idata.
- tap_first  output  1  tap_vld with tap_idx==0; MAC loads bias and clears.
- wr_req  output  1  MAC result ready for write-back to layer-0 memory.
- wr_addr  output  AW  write-back address, y*IMG_W+x of the current output pixel.
- wr_ack  input  1  write accepted in this cycle.

Behaviour:
- Reset: every output is 0, state=IDLE, x=y=0, k=0. Reset mid-frame aborts immediately; there is no partial done pulse.
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: when start=1, go to FETCH with x=y=0, k=0; busy=1 from the next cycle. start is ignored in every other state.
- FETCH: one tap per cycle, k=0..8 (9 cycles).
  - dy=k/3-1, dx=k%3-1; px=x+dx, py=y+dy.
  - In bounds: ird=1, iaddr=py*IMG_W+px.
  - Out of bounds (px<0, px>=IMG_W, py<0, py>=IMG_H): ird=0 and iaddr holds its previous value.
  - After k=8, go to DRAIN.
- Tap pipeline: tap_vld, tap_idx and tap_pad are registered one cycle after the issue cycle, so they line up with idata. tap_first is asserted alongside tap_idx==0.
- DRAIN: lasts 1+MAC_LAT cycles (covers the last tap plus MAC latency), then go to WRITE.
- WRITE: wr_req=1 and wr_addr=y*IMG_W+x.
  - Both hold stable until the cycle in which wr_ack=1; no ird is issued while waiting.
  - On wr_ack, wr_req drops the next cycle.
  - Pixel advance: x+1; if x==IMG_W-1, then x=0 and y+1.
  - After an ack at (IMG_W-1, IMG_H-1), go to DONE; otherwise go to FETCH with k=0.
- wr_ack while wr_req=0 is ignored.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Per-pixel latency with wr_ack tied high: 9 + (1+MAC_LAT) + 1 = 12 cycles at default.
- Corner pixels have 5 padded taps, edge pixels 3, interior pixels 0. Reads never address outside 0..IMG_W*IMG_H-1, and never wrap across rows.
- Coordinate arithmetic uses AW+1-bit signed values or explicit bounds compares; there is no modular wrap.

Test Plan:
- Reset: assert reset low mid-clock -> every output is 0 immediately; after release, busy=0 and start=0 keep the block in IDLE indefinitely.
- Pixel (0,0): start -> taps 0,1,2,3,6 have tap_pad=1 and ird=0; taps 4,5,7,8 read iaddr 0,1,64,65; tap_first occurs on the first tap_vld; wr_req with wr_addr=0 appears 11 cycles after the first issue.
- Interior pixel (5,2): the 9 reads are iaddr 68,69,70,132,133,134,196,197,198 in that order; tap_pad=0 throughout; tap_idx on tap_vld runs 0..8.
- Backpressure: hold wr_ack=0 for 5 cycles at pixel (10,0) -> wr_req=1 and wr_addr=10 stay stable for 6 cycles with no ird; on ack, the next FETCH starts the following cycle at x=11.
- Right edge and last row: pixel (63,0) pads taps 0,1,2,5,8 and the next pixel is (0,1). Pixel (63,63) issues iaddr 4030,4031,4094,4095 only.
- Full frame: wr_ack tied high -> exactly 4096 wr_req cycles with ascending wr_addr 0..4095; done pulses once, 12*4096+1 cycles after start is accepted, with busy falling in the same cycle. A second start during busy has no effect; a start after done runs a new frame.
